// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and stall controller for a 5-stage RV32I pipeline.
//   - EX operand forwarding selects (M has priority over W, x0 never forwarded)
//   - Load-use stall, branch flush, multi-cycle memory stall with timeout,
//     multi-cycle mul/div occupancy of EX
//   - Saturating count of cycles with StallF asserted
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   Rs1D/Rs2D, Rs1E/Rs2E       : source registers in D and E
//   RdE/RdM/RdW, RegWrite*     : destination registers / write enables
//   LoadE, PCSrcE              : load in E, taken branch/jump in E
//   MulDivStartE               : mul/div op present in E
//   MemReqM, MemReadyM         : data-memory request / completion in M
//   ForwardAE/BE               : 00 regfile, 01 ResultW, 10 ALUResultM
//   Stall{F,D,E,M}             : hold pipeline registers
//   Flush{D,E,M,W}             : load bubbles into pipeline registers
//   MemErr                     : one-cycle pulse on memory timeout
//   StallCycles                : saturating count of StallF cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MD_CYCLES   = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MulDivStartE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int MD_W  = $clog2(MD_CYCLES);
    localparam int MEM_W = $clog2(MEM_TIMEOUT);
    localparam logic [MD_W-1:0]  MD_LAST  = MD_W'(MD_CYCLES - 1);
    localparam logic [MEM_W-1:0] MEM_LAST = MEM_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, MD_BUSY} state_t;

    state_t           state, state_n;
    logic [MD_W-1:0]  md_cnt, md_cnt_n;
    logic [MEM_W-1:0] mem_cnt;

    logic lw_stall, mem_stall, md_stall, timeout_hit;

    // Forwarding: M result is newer than W, so it wins.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
    end

    assign lw_stall = LoadE & RegWriteE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    // mem_cnt counts consecutive memory-stall cycles (first stall cycle sees 0),
    // so the abort lands on cycle MEM_TIMEOUT of the wait.
    assign timeout_hit = MemReqM & ~MemReadyM & (mem_cnt == MEM_LAST);
    assign mem_stall   = MemReqM & ~MemReadyM & ~timeout_hit;

    // The cycle a mul/div is first seen in E already stalls; in MD_BUSY the
    // stall drops on the last count so the op leaves EX that cycle.
    assign md_stall = ((state != MD_BUSY) & MulDivStartE) |
                      ((state == MD_BUSY) & (md_cnt != MD_LAST));

    always_comb begin
        state_n  = state;
        md_cnt_n = md_cnt;
        case (state)
            IDLE, MEM_WAIT: begin
                if (mem_stall) begin
                    state_n = MEM_WAIT;
                end else if (MulDivStartE) begin
                    state_n  = MD_BUSY;
                    md_cnt_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            MD_BUSY: begin
                // The older op in M may still be waiting on memory; freeze the count.
                if (!mem_stall) begin
                    if (md_cnt == MD_LAST) state_n  = IDLE;
                    else                   md_cnt_n = md_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A memory stall freezes D/E/M, so any flush there would destroy held
    // instructions; branch/load-use re-evaluate once memory releases.
    assign StallF = lw_stall | mem_stall | md_stall;
    assign StallD = StallF;
    assign StallE = mem_stall | md_stall;
    assign StallM = mem_stall;
    assign FlushW = mem_stall;
    assign FlushD = ~mem_stall & PCSrcE;
    assign FlushE = ~mem_stall & (PCSrcE | lw_stall);
    assign FlushM = ~mem_stall & md_stall;
    assign MemErr = timeout_hit & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            md_cnt      <= '0;
            mem_cnt     <= '0;
            StallCycles <= '0;
        end else begin
            state   <= state_n;
            md_cnt  <= md_cnt_n;
            mem_cnt <= mem_stall ? mem_cnt + 1'b1 : '0;
            if (StallF && StallCycles != '1)
                StallCycles <= StallCycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Scenario tasks drive one pipeline cycle at a time, push the expected
//   control word into a scoreboard queue, then pop and compare it against the
//   DUT on the falling edge. StallCycles is tracked by a bench-side counter.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MD_CYCLES   = 4;
    localparam int MEM_TIMEOUT = 64;
    localparam int CNT_W       = 32;

    // Observation word: {FA[1:0], FB[1:0], SF, SD, SE, SM, FD, FE, FM, FW, Err}
    localparam logic [12:0] NONE  = 13'h000;
    localparam logic [12:0] B_SF  = 13'h100;
    localparam logic [12:0] B_SD  = 13'h080;
    localparam logic [12:0] B_SE  = 13'h040;
    localparam logic [12:0] B_SM  = 13'h020;
    localparam logic [12:0] B_FD  = 13'h010;
    localparam logic [12:0] B_FE  = 13'h008;
    localparam logic [12:0] B_FM  = 13'h004;
    localparam logic [12:0] B_FW  = 13'h002;
    localparam logic [12:0] B_ERR = 13'h001;
    localparam logic [12:0] E_LW  = B_SF | B_SD | B_FE;
    localparam logic [12:0] E_BR  = B_FD | B_FE;
    localparam logic [12:0] E_MEM = B_SF | B_SD | B_SE | B_SM | B_FW;
    localparam logic [12:0] E_MD  = B_SF | B_SD | B_SE | B_FM;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwe, rwm, rww, loade, pcsrc, mdstart, memreq, memrdy;
    } in_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    in_t  stim = '{default: '0};

    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushM, FlushW, MemErr;
    logic [CNT_W-1:0] StallCycles;

    int vectors = 0;
    int miscompares = 0;
    logic [CNT_W-1:0] exp_sc = '0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_CYCLES(MD_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(stim.rs1d), .Rs2D(stim.rs2d), .Rs1E(stim.rs1e), .Rs2E(stim.rs2e),
        .RdE(stim.rde), .RdM(stim.rdm), .RdW(stim.rdw),
        .RegWriteE(stim.rwe), .RegWriteM(stim.rwm), .RegWriteW(stim.rww),
        .LoadE(stim.loade), .PCSrcE(stim.pcsrc), .MulDivStartE(stim.mdstart),
        .MemReqM(stim.memreq), .MemReadyM(stim.memrdy),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .MemErr(MemErr), .StallCycles(StallCycles)
    );

    function automatic logic [12:0] outs();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushM, FlushW, MemErr};
    endfunction

    function automatic logic [12:0] fa(input logic [1:0] x);
        return {x, 11'b0};
    endfunction

    function automatic logic [12:0] fb(input logic [1:0] x);
        return {2'b00, x, 9'b0};
    endfunction

    task automatic test_reset();
        logic [12:0] e, got;
        reset = 1'b1;
        stim  = '{default: '0};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_sc = '0;
        exp_q.push_back(NONE);
        @(negedge clk);
        got = outs(); e = exp_q.pop_front(); vectors++;
        if (got !== e || StallCycles !== exp_sc) begin
            miscompares++;
            $display("FAIL reset: got %h sc=%0d, want %h sc=%0d", got, StallCycles, e, exp_sc);
        end
    endtask

    task automatic test_forwarding();
        logic [12:0] e, got;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            stim = '{default: '0};
            case (i)
                0: begin // M and W both match Rs1E: M wins
                    stim.rwm = 1; stim.rdm = 5; stim.rww = 1; stim.rdw = 5; stim.rs1e = 5;
                    e = fa(2'b10);
                end
                1: begin // M writes x0: fall through to W
                    stim.rwm = 1; stim.rdm = 0; stim.rww = 1; stim.rdw = 5; stim.rs1e = 5;
                    e = fa(2'b01);
                end
                2: begin // M matches but not writing
                    stim.rwm = 0; stim.rdm = 9; stim.rww = 1; stim.rdw = 9; stim.rs2e = 9;
                    e = fb(2'b01);
                end
                3: begin // x0 never forwarded
                    stim.rwm = 1; stim.rdm = 0; stim.rww = 1; stim.rdw = 0;
                    e = NONE;
                end
                4: begin // independent A from W, B from M
                    stim.rs1e = 3; stim.rs2e = 4; stim.rwm = 1; stim.rdm = 4; stim.rww = 1; stim.rdw = 3;
                    e = fa(2'b01) | fb(2'b10);
                end
                default: begin // no writers
                    stim.rdm = 5; stim.rdw = 5; stim.rs1e = 5; stim.rs2e = 5;
                    e = NONE;
                end
            endcase
            exp_q.push_back(e);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); vectors++;
            if (got !== e || StallCycles !== exp_sc) begin
                miscompares++;
                $display("FAIL fwd[%0d]: got %h sc=%0d, want %h sc=%0d", i, got, StallCycles, e, exp_sc);
            end
            if (e[8]) exp_sc++;
        end
    endtask

    task automatic test_load_use();
        logic [12:0] e, got;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            stim = '{default: '0};
            stim.rs1d = 7;
            case (c)
                0: begin stim.loade = 1; stim.rwe = 1; stim.rde = 7; e = E_LW; end
                1: begin stim.rwm = 1; stim.rdm = 7; e = NONE; end      // bubble in E
                default: begin stim.rs1d = 0; stim.rs1e = 7; stim.rww = 1; stim.rdw = 7; e = fa(2'b01); end
            endcase
            exp_q.push_back(e);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); vectors++;
            if (got !== e || StallCycles !== exp_sc) begin
                miscompares++;
                $display("FAIL load_use[%0d]: got %h sc=%0d, want %h sc=%0d", c, got, StallCycles, e, exp_sc);
            end
            if (e[8]) exp_sc++;
        end
    endtask

    task automatic test_branch_mem();
        logic [12:0] e, got;
        logic [CNT_W-1:0] base;
        base = exp_sc;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            stim = '{default: '0};
            if (c < 4) begin stim.pcsrc = 1; stim.memreq = 1; end
            if (c == 3) stim.memrdy = 1;
            e = (c < 3) ? E_MEM : (c == 3) ? E_BR : NONE;
            exp_q.push_back(e);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); vectors++;
            if (got !== e || StallCycles !== exp_sc) begin
                miscompares++;
                $display("FAIL branch_mem[%0d]: got %h sc=%0d, want %h sc=%0d", c, got, StallCycles, e, exp_sc);
            end
            if (e[8]) exp_sc++;
        end
        vectors++;
        if (StallCycles !== base + 3) begin
            miscompares++;
            $display("FAIL branch_mem_count: got %0d, want %0d", StallCycles, base + 3);
        end
    endtask

    task automatic test_muldiv(input bit inject);
        logic [12:0] e, got;
        int n, se_cnt, fm_cnt;
        n = inject ? 8 : 6;
        se_cnt = 0; fm_cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            stim = '{default: '0};
            stim.mdstart = (c < n - 1);
            if (inject && (c == 2 || c == 3)) stim.memreq = 1;
            if (inject && c == 4) begin stim.memreq = 1; stim.memrdy = 1; end
            if (inject && (c == 2 || c == 3)) e = E_MEM;
            else if (c < n - 2)               e = E_MD;
            else                              e = NONE;
            exp_q.push_back(e);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); vectors++;
            if (StallE) se_cnt++;
            if (FlushM) fm_cnt++;
            if (got !== e || StallCycles !== exp_sc) begin
                miscompares++;
                $display("FAIL muldiv%s[%0d]: got %h sc=%0d, want %h sc=%0d",
                         inject ? "_mem" : "", c, got, StallCycles, e, exp_sc);
            end
            if (e[8]) exp_sc++;
        end
        vectors++;
        if (se_cnt != (inject ? MD_CYCLES + 2 : MD_CYCLES) || fm_cnt != MD_CYCLES) begin
            miscompares++;
            $display("FAIL muldiv_len: got StallE=%0d FlushM=%0d, want StallE=%0d FlushM=%0d",
                     se_cnt, fm_cnt, inject ? MD_CYCLES + 2 : MD_CYCLES, MD_CYCLES);
        end
    endtask

    task automatic test_timeout();
        logic [12:0] e, got;
        for (int c = 1; c <= MEM_TIMEOUT + 1; c++) begin
            @(posedge clk); #1;
            stim = '{default: '0};
            stim.memreq = (c <= MEM_TIMEOUT);
            e = (c < MEM_TIMEOUT) ? E_MEM : (c == MEM_TIMEOUT) ? B_ERR : NONE;
            exp_q.push_back(e);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); vectors++;
            if (got !== e || StallCycles !== exp_sc) begin
                miscompares++;
                $display("FAIL timeout[%0d]: got %h sc=%0d, want %h sc=%0d", c, got, StallCycles, e, exp_sc);
            end
            if (e[8]) exp_sc++;
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e, got;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            stim = '{default: '0};
            case (c)
                0: begin stim.pcsrc = 1; e = E_BR; end
                1: begin stim.loade = 1; stim.rwe = 1; stim.rde = 6; stim.rs2d = 6; e = E_LW; end
                2: begin stim.loade = 1; stim.rwe = 1; stim.rde = 3; stim.rs1d = 3; e = E_LW; end
                default: begin stim.loade = 1; stim.rwe = 1; stim.rde = 0; stim.rs1d = 0; e = NONE; end
            endcase
            exp_q.push_back(e);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); vectors++;
            if (got !== e || StallCycles !== exp_sc) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %h sc=%0d, want %h sc=%0d", c, got, StallCycles, e, exp_sc);
            end
            if (e[8]) exp_sc++;
        end
    endtask

    task automatic test_reset_mid_md();
        logic [12:0] e, got;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            stim = '{default: '0};
            reset = (c == 2);
            if (c < 2) stim.mdstart = 1;
            if (c == 4) stim.memreq = 1;   // fresh memory stall after reset
            if (c == 2) begin
                exp_sc = '0;
                continue;
            end
            e = (c < 2) ? E_MD : (c == 4) ? E_MEM : NONE;
            exp_q.push_back(e);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); vectors++;
            if (got !== e || StallCycles !== exp_sc) begin
                miscompares++;
                $display("FAIL reset_mid_md[%0d]: got %h sc=%0d, want %h sc=%0d", c, got, StallCycles, e, exp_sc);
            end
            if (e[8]) exp_sc++;
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_mem();
        test_muldiv(1'b0);
        test_muldiv(1'b1);
        test_timeout();
        test_back_to_back();
        test_reset_mid_md();
        @(posedge clk); #1 stim = '{default: '0};
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RV32I core. It sequences the EX-stage forwarding muxes by driving ForwardAE/ForwardBE. It generates the per-stage stall and flush controls for load-use hazards, taken branches, multi-cycle data-memory accesses and the multi-cycle mul/div unit in EX. It also counts stall cycles for performance monitoring.

Parameters:
MD_CYCLES, 4, number of cycles a mul/div op occupies EX (2..16).
MEM_TIMEOUT, 64, maximum cycles spent waiting for MemReadyM before abort (>=2).
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  synchronous, active-high reset.
Rs1D, Rs2D  input  5  source register addresses in D.
Rs1E, Rs2E  input  5  source register addresses in E.
RdE, RdM, RdW  input  5  destination register addresses in E/M/W.
RegWriteE, RegWriteM, RegWriteW  input  1  register write enables per stage.
LoadE  input  1  instruction in E is a load.
PCSrcE  input  1  taken branch/jump resolved in E.
MulDivStartE  input  1  mul/div op present in E.
MemReqM  input  1  load/store in M requesting memory.
MemReadyM  input  1  memory completes the access this cycle.
ForwardAE, ForwardBE  output  2  forwarding select: 00 regfile, 01 ResultW, 10 ALUResultM.
StallF, StallD, StallE, StallM  output  1  hold the corresponding pipeline register.
FlushD, FlushE, FlushM, FlushW  output  1  load a bubble into the corresponding pipeline register.
MemErr  output  1  one-cycle pulse on memory timeout.
StallCycles  output  CNT_W  saturating count of cycles with StallF=1.

Behaviour:
- Reset (synchronous): FSM to IDLE, md_cnt=0, mem_cnt=0, StallCycles=0, MemErr=0. Forward and stall/flush outputs are combinational and evaluate to 0 when no hazard is present.
- Forwarding (combinational, per source X in {A,B}):
  - 10 if RegWriteM and RdM!=0 and RdM==Rs1E/Rs2E.
  - Otherwise 01 if RegWriteW and RdW!=0 and RdW==Rs1E/Rs2E.
  - Otherwise 00.
  - M has priority over W. x0 is never forwarded. Encoding 11 is never driven.
- lwStall = LoadE & RegWriteE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D). It asserts StallF, StallD and FlushE for exactly one cycle per hazard.
- Branch: PCSrcE asserts FlushD and FlushE. LoadE and PCSrcE are mutually exclusive by decode.
- memStall = MemReqM & !MemReadyM & !timeout_hit. It asserts StallF, StallD, StallE, StallM and FlushW.
  - memStall overrides all other flushes to D/E/M: FlushD/E/M are forced to 0 while memStall=1, so a branch or lwStall re-evaluates after release.
- FSM states: IDLE, MEM_WAIT, MD_BUSY.
  - IDLE -> MEM_WAIT: on memStall. mem_cnt counts cycles in MEM_WAIT.
  - MEM_WAIT -> IDLE: on MemReadyM; stalls drop in that same cycle.
  - Timeout: when mem_cnt==MEM_TIMEOUT-1 and !MemReadyM, timeout_hit=1 for that cycle. MemErr pulses, stalls drop, FSM -> IDLE, mem_cnt -> 0.
  - IDLE -> MD_BUSY: on MulDivStartE with !memStall; md_cnt loads 0.
  - In MD_BUSY: StallF, StallD and StallE are asserted and FlushM inserts bubbles. md_cnt increments only in cycles with memStall=0, so the older op in M can still wait on memory (memStall has priority).
  - MD_BUSY -> IDLE: when md_cnt==MD_CYCLES-1 and !memStall; stalls drop that cycle.
  - The first cycle of a mul/div op (start seen in IDLE) also asserts the stalls. Total EX occupancy is MD_CYCLES cycles.
- lwStall and mul/div in the same cycle cannot conflict (one E instruction); StallF/StallD is the OR of all sources.
- StallCycles increments when StallF=1 and saturates at all-ones.
- Reset asserted mid-MEM_WAIT or mid-MD_BUSY aborts the operation next edge. No MemErr is generated by reset.

Test Plan:
- add x5 in M, sub in E reads x5 as Rs1E; simultaneously RdW=5 with RegWriteW -> ForwardAE=10; with RdM=0 instead -> no forward from M, ForwardAE=01 (W).
- Load to x7 in E, D reads x7 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=01 on the following E cycle.
- PCSrcE=1 while MemReqM=1 and MemReadyM=0 for 3 cycles -> FlushD=FlushE=0 and all stalls=1 for 3 cycles; after ready, FlushD=FlushE=1; StallCycles increases by 3.
- MulDivStartE with MD_CYCLES=4 -> StallE=1 and FlushM=1 for 4 cycles, then IDLE; inject 2 memStall cycles mid-op -> total 6 cycles.
- MemReqM held with MemReadyM=0 and MEM_TIMEOUT=64 -> stalls for 63 cycles, MemErr=1 on cycle 64, stalls released.
- Reset asserted during MD_BUSY -> next cycle all outputs 0, state IDLE, StallCycles=0.
